// File: rtl/clock_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : clock_display_driver
// Description : Binary minute/hour to BCD (sequential double-dabble), shown as
//               HH.MM on a 4-digit multiplexed common-anode 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_display_driver #(
    parameter int CLK_HZ             = 100_000_000,
    parameter int SCAN_HZ            = 1000,
    parameter bit LEADING_ZERO_BLANK = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [7:0] min_in,
    input  logic [7:0] hour_in,
    input  logic       sec_tick_in,
    output logic [3:0] an_out,
    output logic [6:0] seg_out,
    output logic       dp_out
);

    localparam int                 c_DIV       = CLK_HZ / SCAN_HZ;
    localparam int                 c_CNT_W     = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(c_DIV - 1);
    localparam logic [6:0]         c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0]         c_SEG_OFF   = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    logic [c_CNT_W-1:0] r_scan_cnt;
    logic [1:0]         r_digit_idx;
    logic               r_post_reset;
    logic               r_colon;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_step;
    logic [19:0]        r_min_sr;
    logic [19:0]        r_hour_sr;
    logic [3:0]         r_min_ones, r_min_tens, r_hour_ones, r_hour_tens;
    logic               r_min_oor, r_hour_oor;
    logic               w_scan_wrap;
    logic               w_frame_start;
    logic [3:0]         w_nibble;
    logic               w_dash;
    logic [3:0]         w_an;
    logic [6:0]         w_seg;
    logic               w_dp;

    // Shift register layout: {hundreds, tens, ones, binary}
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5)
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = c_SEG_OFF;
        endcase
        return s;
    endfunction

    assign w_scan_wrap   = (r_scan_cnt == c_SCAN_LAST);
    assign w_frame_start = r_post_reset | (w_scan_wrap & (r_digit_idx == 2'd3));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_scan_cnt   <= '0;
            r_digit_idx  <= 2'd0;
            r_post_reset <= 1'b1;
            r_colon      <= 1'b0;
        end else begin
            r_post_reset <= 1'b0;
            if (w_scan_wrap) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + c_CNT_W'(1);
            end
            if (sec_tick_in)
                r_colon <= ~r_colon;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_frame_start) w_state_nxt = ST_CONVERT;
            ST_CONVERT: if (r_step == 3'd7) w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_step      <= 3'd0;
            r_min_sr    <= 20'd0;
            r_hour_sr   <= 20'd0;
            r_min_ones  <= 4'd0;
            r_min_tens  <= 4'd0;
            r_hour_ones <= 4'd0;
            r_hour_tens <= 4'd0;
            r_min_oor   <= 1'b0;
            r_hour_oor  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_min_sr  <= {12'd0, min_in};
                        r_hour_sr <= {12'd0, hour_in};
                        r_step    <= 3'd0;
                    end
                end
                ST_CONVERT: begin
                    r_min_sr  <= dd_step(r_min_sr);
                    r_hour_sr <= dd_step(r_hour_sr);
                    r_step    <= r_step + 3'd1;
                end
                ST_LOAD: begin
                    // A nonzero hundreds digit means the value cannot fit in two digits
                    r_min_ones  <= r_min_sr[11:8];
                    r_min_tens  <= r_min_sr[15:12];
                    r_min_oor   <= |r_min_sr[19:16];
                    r_hour_ones <= r_hour_sr[11:8];
                    r_hour_tens <= r_hour_sr[15:12];
                    r_hour_oor  <= |r_hour_sr[19:16];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nibble = 4'd0;
        w_dash   = 1'b0;
        case (r_digit_idx)
            2'd0: begin w_nibble = r_min_ones;  w_dash = r_min_oor;  end
            2'd1: begin w_nibble = r_min_tens;  w_dash = r_min_oor;  end
            2'd2: begin w_nibble = r_hour_ones; w_dash = r_hour_oor; end
            default: begin w_nibble = r_hour_tens; w_dash = r_hour_oor; end
        endcase
        w_an  = ~(4'b0001 << r_digit_idx);
        w_seg = w_dash ? c_SEG_DASH : seg_lut(w_nibble);
        if (LEADING_ZERO_BLANK && (r_digit_idx == 2'd3) &&
            (r_hour_tens == 4'd0) && !r_hour_oor) begin
            w_an  = 4'b1111;
            w_seg = c_SEG_OFF;
        end
        w_dp = ~((r_digit_idx == 2'd2) & r_colon);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            an_out  <= 4'b1111;
            seg_out <= c_SEG_OFF;
            dp_out  <= 1'b1;
        end else begin
            an_out  <= w_an;
            seg_out <= w_seg;
            dp_out  <= w_dp;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_display_driver
// Description : Self-checking bench for clock_display_driver (DIV = 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_display_driver;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic [7:0] min_in = 8'd0;
    logic [7:0] hour_in = 8'd0;
    logic       sec_tick_in = 1'b0;
    logic [3:0] an_out;
    logic [6:0] seg_out;
    logic       dp_out;

    always #5 clk_in = ~clk_in;

    clock_display_driver #(
        .CLK_HZ             (1000),
        .SCAN_HZ            (100),
        .LEADING_ZERO_BLANK (1'b1)
    ) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .min_in      (min_in),
        .hour_in     (hour_in),
        .sec_tick_in (sec_tick_in),
        .an_out      (an_out),
        .seg_out     (seg_out),
        .dp_out      (dp_out)
    );

    typedef struct {
        int due;
        int m;
        int h;
    } cap_t;

    typedef struct {
        int          m;
        int          h;
        logic [27:0] segs;   // {d3, d2, d1, d0}
        bit          blank3;
    } vec_t;

    logic [6:0] code_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int   n_tests = 0;
    int   n_fail  = 0;
    int   j = 0;             // cycles since reset release
    int   shown_min = 0;
    int   shown_hour = 0;
    bit   colon = 1'b0;
    cap_t pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @j=%0d: got %0b expected %0b", name, j, act, exp);
        end
    endtask

    // One clock; reference model advanced with the inputs the DUT sampled at that edge
    task automatic step();
        logic r, t;
        int m, h, d, v, dv;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        bit blank;
        r = reset_in; t = sec_tick_in; m = int'(min_in); h = int'(hour_in);
        @(posedge clk_in);
        #1;
        if (r) begin
            j = 0; shown_min = 0; shown_hour = 0; colon = 1'b0;
            pend.delete();
            chk("rst_an", 32'(an_out), 32'(4'b1111));
            chk("rst_seg", 32'(seg_out), 32'(7'b1111111));
            chk("rst_dp", 32'(dp_out), 32'(1'b1));
        end else begin
            j++;
            while (pend.size() > 0 && pend[0].due <= j) begin
                shown_min  = pend[0].m;
                shown_hour = pend[0].h;
                void'(pend.pop_front());
            end
            d     = ((j - 1) / 10) % 4;
            v     = (d < 2) ? shown_min : shown_hour;
            dv    = (d % 2 == 0) ? v % 10 : v / 10;
            e_seg = (v > 99) ? 7'b0111111 : code_tab[dv];
            blank = (d == 3) && (shown_hour < 10);
            e_an  = blank ? 4'b1111 : an_tab[d];
            e_dp  = (d == 2 && colon) ? 1'b0 : 1'b1;
            chk("an", 32'(an_out), 32'(e_an));
            if (!blank) chk("seg", 32'(seg_out), 32'(e_seg));
            chk("dp", 32'(dp_out), 32'(e_dp));
            if (j == 1 || j % 40 == 0) pend.push_back('{j + 10, m, h});
            if (t) colon = !colon;
        end
    endtask

    task automatic wait_frame();
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            step();
            if (j > 0 && j % 40 == 0) hit = 1'b1;
        end
        if (!hit) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic step_until(input int target);
        for (int k = 0; k < 200 && j != target; k++) step();
        chk("reach_j", 32'(j), 32'(target));
    endtask

    vec_t vecs [6];
    int   lows;

    initial begin
        vecs[0] = '{0,   0,  {7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000}, 1'b1};
        vecs[1] = '{37,  12, {7'b1111001, 7'b0100100, 7'b0110000, 7'b1111000}, 1'b0};
        vecs[2] = '{59,  5,  {7'b1111111, 7'b0010010, 7'b0010010, 7'b0010000}, 1'b1};
        vecs[3] = '{8,   120,{7'b0111111, 7'b0111111, 7'b1000000, 7'b0000000}, 1'b0};
        vecs[4] = '{200, 23, {7'b0100100, 7'b0110000, 7'b0111111, 7'b0111111}, 1'b0};
        vecs[5] = '{99,  10, {7'b1111001, 7'b1000000, 7'b0010000, 7'b0010000}, 1'b0};

        // Reset, including a tick that must be ignored
        reset_in = 1'b1;
        step();
        sec_tick_in = 1'b1;
        step();
        sec_tick_in = 1'b0;
        step();
        reset_in = 1'b0;

        // Table vectors: hold inputs across a frame, then sample each digit mid-window
        foreach (vecs[i]) begin
            min_in  = 8'(vecs[i].m);
            hour_in = 8'(vecs[i].h);
            wait_frame();
            repeat (45) step();
            for (int k = 0; k < 40; k++) begin
                step();
                if ((j - 1) % 10 == 5) begin
                    int d;
                    d = ((j - 1) / 10) % 4;
                    if (d == 3 && vecs[i].blank3) begin
                        chk($sformatf("vec%0d_blank", i), 32'(an_out), 32'(4'b1111));
                    end else begin
                        chk($sformatf("vec%0d_an%0d", i, d), 32'(an_out), 32'(an_tab[d]));
                        chk($sformatf("vec%0d_seg%0d", i, d), 32'(seg_out), 32'(vecs[i].segs[d*7 +: 7]));
                    end
                end
            end
        end

        // Mid-frame input change is not visible until the following frame's LOAD
        min_in = 8'd37; hour_in = 8'd12;
        wait_frame();
        wait_frame();
        repeat (15) step();
        min_in = 8'd45;
        step();
        chk("midframe_hold_d1", 32'(seg_out), 32'(7'b0110000));
        wait_frame();
        repeat (9) step();
        chk("old_d0_before_load", 32'(seg_out), 32'(7'b1111000));
        step();
        chk("new_d0_after_load", 32'(seg_out), 32'(7'b0010010));
        repeat (10) step();
        chk("new_d1", 32'(seg_out), 32'(7'b0011001));

        // Colon: two ticks 50 cycles apart
        sec_tick_in = 1'b1;
        step();
        sec_tick_in = 1'b0;
        lows = 0;
        for (int k = 0; k < 49; k++) begin
            step();
            if (dp_out == 1'b0) lows++;
        end
        chk("colon_on_seen", 32'(lows > 0), 32'd1);
        sec_tick_in = 1'b1;
        step();
        sec_tick_in = 1'b0;
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (dp_out == 1'b0) lows++;
        end
        chk("colon_off_after", 32'(lows), 32'd0);

        // Reset four cycles into CONVERT aborts; re-capture after release
        min_in = 8'd59; hour_in = 8'd3;
        wait_frame();
        repeat (4) step();
        reset_in = 1'b1;
        step();
        chk("abort_an", 32'(an_out), 32'(4'b1111));
        chk("abort_seg", 32'(seg_out), 32'(7'b1111111));
        step();
        reset_in = 1'b0;
        step_until(15);
        chk("recap_d1", 32'(seg_out), 32'(7'b0010010));
        step_until(45);
        chk("recap_d0", 32'(seg_out), 32'(7'b0010000));

        // Randomised inputs and ticks, with one random reset burst
        for (int pass = 0; pass < 2; pass++) begin
            repeat (500) begin
                if ($urandom_range(0, 14) == 0) begin
                    min_in  = 8'($urandom_range(0, 127));
                    hour_in = 8'($urandom_range(0, 127));
                end
                sec_tick_in = ($urandom_range(0, 19) == 0);
                step();
            end
            sec_tick_in = 1'b0;
            if (pass == 0) begin
                reset_in = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                reset_in = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
